// File: rtl/serial_add_ctrl.sv
// Bit-serial adder sequencer: streams two WIDTH-bit operands LSB-first through one 1-bit adder cell.
// Optional subtract mode is compiled in with `define SERIAL_ADD_SUB_EN (adds the 'sub' port).
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(WIDTH)
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [1:0]       state;
    logic [1:0]       state_next;
    logic [WIDTH-1:0] opa_sr;
    logic [WIDTH-1:0] opb_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;

    logic             ha1_s_c;
    logic             ha1_c_c;
    logic             ha2_s_c;
    logic             ha2_c_c;
    logic             carry_next_c;
    logic [WIDTH-1:0] res_next_c;
    logic [WIDTH-1:0] opb_load_c;
    logic             carry_in_c;
    logic             last_c;

    // Shared cell: two half adders plus an OR for the carry.
    always_comb begin
        ha1_s_c      = opa_sr[0] ^ opb_sr[0];
        ha1_c_c      = opa_sr[0] & opb_sr[0];
        ha2_s_c      = ha1_s_c ^ carry;
        ha2_c_c      = ha1_s_c & carry;
        carry_next_c = ha1_c_c | ha2_c_c;
        res_next_c   = {ha2_s_c, res_sr[WIDTH-1:1]};
        last_c       = (cnt == LAST);
    end

    // Subtract is a + ~b + 1, so cout=1 means no borrow.
    always_comb begin
`ifdef SERIAL_ADD_SUB_EN
        opb_load_c = sub ? ~b : b;
        carry_in_c = sub;
`else
        opb_load_c = b;
        carry_in_c = 1'b0;
`endif
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (start) state_next = S_RUN;
            S_RUN:   if (last_c) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Datapath and registered handshake outputs.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            opa_sr <= '0;
            opb_sr <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            busy <= (state_next == S_RUN) || (state_next == S_DONE);
            done <= (state_next == S_DONE);
            if (state == S_IDLE) begin
                if (start) begin
                    opa_sr <= a;
                    opb_sr <= opb_load_c;
                    carry  <= carry_in_c;
                    cnt    <= '0;
                end
            end else if (state == S_RUN) begin
                opa_sr <= {1'b0, opa_sr[WIDTH-1:1]};
                opb_sr <= {1'b0, opb_sr[WIDTH-1:1]};
                res_sr <= res_next_c;
                carry  <= carry_next_c;
                // Result lands in sum on the same edge DONE is entered.
                if (last_c) begin
                    sum  <= res_next_c;
                    cout <= carry_next_c;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: arithmetic reference model plus directed and random operations.
module tb_serial_add_ctrl;

    localparam int W = 8;

    logic         sys_clk;
    logic         sys_rst;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .start   (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub     (sub),
`endif
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .sum     (sum),
        .cout    (cout)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference result from plain arithmetic.
    function automatic logic [W:0] ref_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
        logic [W:0] r;
        if (s) begin
            r[W-1:0] = x - y;
            r[W]     = (x >= y);
        end else begin
            r = {1'b0, x} + {1'b0, y};
        end
        return r;
    endfunction

    function automatic logic cur_sub();
`ifdef SERIAL_ADD_SUB_EN
        return sub;
`else
        return 1'b0;
`endif
    endfunction

    // Model: an accepted op keeps the block busy for W+1 cycles, the last of which is the done cycle.
    int           m_left;
    logic [W:0]   m_pend;
    logic [W-1:0] m_sum;
    logic         m_cout;

    always @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            m_left = 0;
            m_sum  = '0;
            m_cout = 1'b0;
        end else if (m_left == 0) begin
            if (start === 1'b1) begin
                m_pend = ref_op(a, b, cur_sub());
                m_left = W + 1;
            end
        end else begin
            m_left--;
            if (m_left == 1) begin
                m_sum  = m_pend[W-1:0];
                m_cout = m_pend[W];
            end
        end
    end

    always @(negedge sys_clk) begin
        if (chk_en && !sys_rst) begin
            chk("busy", longint'(busy), longint'(m_left > 0));
            chk("done", longint'(done), longint'(m_left == 1));
            chk("sum", longint'(sum), longint'(m_sum));
            chk("cout", longint'(cout), longint'(m_cout));
        end
    end

    task automatic set_sub(input logic s);
`ifdef SERIAL_ADD_SUB_EN
        sub = s;
`else
        if (s) $display("note: subtract requested without subtract support");
`endif
    endtask

    // One operation from IDLE; optional junk start pulses and operand churn while busy.
    task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input logic os, input bit junk,
                         output logic [W-1:0] rs, output logic rc, output int nbusy, output int done_at);
        a = oa;
        b = ob;
        set_sub(os);
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        nbusy = 0;
        done_at = 0;
        rs = '0;
        rc = 1'b0;
        while (busy && nbusy < 64) begin
            nbusy++;
            if (done) begin
                done_at = nbusy;
                rs = sum;
                rc = cout;
                start = 1'b0;
            end else if (junk) begin
                start = ($urandom_range(0, 3) == 0);
                a = W'($urandom);
                b = W'($urandom);
            end
            @(negedge sys_clk);
        end
        start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (busy && n < 64) begin
            n++;
            @(negedge sys_clk);
        end
        chk(nm, longint'(busy), 0);
    endtask

    logic [W-1:0] rs;
    logic         rc;
    int           nb;
    int           da;

    initial begin
        int         t[$];
        int         n;
        logic [W:0] e;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic       rsub;

        sys_rst = 1'b1;
        start   = 1'b0;
        a       = '0;
        b       = '0;
        set_sub(1'b0);
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_done", longint'(done), 0);
        chk("rst_sum", longint'(sum), 0);
        chk("rst_cout", longint'(cout), 0);
        chk_en = 1;
        @(negedge sys_clk);

        do_op(8'h5A, 8'h3C, 1'b0, 0, rs, rc, nb, da);
        chk("t1_busy_cycles", longint'(nb), 9);
        chk("t1_done_cycle", longint'(da), 9);
        chk("t1_sum", longint'(rs), 64'h96);
        chk("t1_cout", longint'(rc), 0);

        do_op(8'hFF, 8'h01, 1'b0, 0, rs, rc, nb, da);
        chk("t2a_sum", longint'(rs), 0);
        chk("t2a_cout", longint'(rc), 1);
        do_op(8'h00, 8'h00, 1'b0, 0, rs, rc, nb, da);
        chk("t2b_sum", longint'(rs), 0);
        chk("t2b_cout", longint'(rc), 0);

        // start held high: one result every W+2 cycles
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        for (int i = 0; i < 35; i++) begin
            @(negedge sys_clk);
            if (done) begin
                t.push_back(i);
                chk("t3_sum", longint'(sum), 3);
            end
        end
        start = 1'b0;
        chk("t3_done_count", longint'(t.size()), 3);
        if (t.size() >= 3) begin
            chk("t3_period_a", longint'(t[1] - t[0]), 10);
            chk("t3_period_b", longint'(t[2] - t[1]), 10);
        end
        wait_idle("t3_idle");
        @(negedge sys_clk);

        // start pulsed mid-run is ignored
        a = 8'h01;
        b = 8'h02;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (2) @(negedge sys_clk);
        a = 8'h70;
        b = 8'h70;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        n = 0;
        while (!done && n < 64) begin
            n++;
            @(negedge sys_clk);
        end
        chk("t4_done_seen", longint'(done), 1);
        chk("t4_sum", longint'(sum), 3);
        wait_idle("t4_idle");
        @(negedge sys_clk);

        // reset mid-run aborts
        a = 8'hAA;
        b = 8'h55;
        start = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        repeat (3) @(negedge sys_clk);
        #2 sys_rst = 1'b1;
        #1;
        chk("t5_rst_busy", longint'(busy), 0);
        chk("t5_rst_done", longint'(done), 0);
        chk("t5_rst_sum", longint'(sum), 0);
        chk("t5_rst_cout", longint'(cout), 0);
        @(negedge sys_clk);
        sys_rst = 1'b0;
        repeat (12) @(negedge sys_clk);
        do_op(8'hAA, 8'h55, 1'b0, 0, rs, rc, nb, da);
        chk("t5_sum", longint'(rs), 64'hFF);
        chk("t5_cout", longint'(rc), 0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(8'h10, 8'h01, 1'b1, 0, rs, rc, nb, da);
        chk("t6a_sum", longint'(rs), 64'h0F);
        chk("t6a_cout", longint'(rc), 1);
        do_op(8'h01, 8'h02, 1'b1, 0, rs, rc, nb, da);
        chk("t6b_sum", longint'(rs), 64'hFF);
        chk("t6b_cout", longint'(rc), 0);
`endif

        for (int i = 0; i < 200; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
`ifdef SERIAL_ADD_SUB_EN
            rsub = 1'($urandom_range(0, 1));
`else
            rsub = 1'b0;
`endif
            e = ref_op(ra, rb, rsub);
            do_op(ra, rb, rsub, 1, rs, rc, nb, da);
            chk("rnd_sum", longint'(rs), longint'(e[W-1:0]));
            chk("rnd_cout", longint'(rc), longint'(e[W]));
            chk("rnd_done_cycle", longint'(da), W + 1);
            repeat ($urandom_range(0, 3)) @(negedge sys_clk);
        end

        repeat (2) @(negedge sys_clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
